fetch_controller: RTL and testbench
===================================

# fetch_controller

Sequences instruction fetch from the instruction memory for the MIPS core. It owns the PC and issues word requests to the instruction memory over a req/ready handshake that tolerates variable latency. It holds each returned instruction until the decode stage accepts it, and handles branch/jump redirects, including discarding a stale in-flight response. It sits between the instruction memory (word-indexed, base 0x3000, 4096 words) and the IF/ID register.

## Interface
- PC_RESET, 32'h0000_3000, PC value after reset
- PC_LOW, 32'h0000_3000, lowest legal fetch address
- PC_HIGH, 32'h0000_6FFC, highest legal fetch address (last word of 4096-word memory)
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- im_req  out  1  request valid to instruction memory
- im_addr  out  32  byte address of the requested word
- im_ready  in  1  memory response valid this cycle; sampled only while im_req=1
- im_rdata  in  32  instruction word, valid when im_ready=1
- instr_valid  out  1  instr/pc_out/exc_adel are valid for decode
- instr  out  32  held instruction word
- pc_out  out  32  address of the held instruction
- exc_adel  out  1  held entry is a fetch address exception (instr=0)
- stall  in  1  decode cannot accept this cycle
- redirect_valid  in  1  branch/jump taken; load redirect_pc
- redirect_pc  in  32  new fetch address

## Operation
- Registers: pc[31:0], req_addr[31:0] (address of the outstanding request), ibuf[31:0], exc flag, 2-bit state.
- States: START, REQ, HOLD, DROP.
- Accept = instr_valid & ~stall. A held entry is retired only on accept.
- Address is legal iff PC_LOW ≤ pc ≤ PC_HIGH and pc[1:0]=0.
- START: im_req=0. Next state is REQ.
- REQ with legal pc: im_req=1, im_addr=pc, req_addr<=pc.
  - redirect_valid: pc<=redirect_pc. If im_ready, go to REQ and discard the data; otherwise go to DROP.
  - Else im_ready: ibuf<=im_rdata, exc<=0, go to HOLD.
  - Else stay in REQ.
- REQ with illegal pc: im_req=0, ibuf<=0, exc<=1, go to HOLD. redirect_valid in that cycle instead sets pc<=redirect_pc and stays in REQ.
- HOLD: instr_valid=~redirect_valid, instr=ibuf, pc_out=pc, exc_adel=exc.
  - redirect_valid: pc<=redirect_pc, go to REQ. The held entry is dropped and never accepted.
  - Else accept with exc=0: pc<=pc+4 (mod 2^32), go to REQ.
  - Else accept with exc=1: stay in HOLD with instr_valid forced 0 until a redirect arrives. Fetch halts.
  - Else (stalled): hold everything.
- DROP: im_req=1, im_addr=req_addr, unchanged until im_ready.
  - On im_ready: discard im_rdata, go to REQ.
  - redirect_valid in DROP: pc<=redirect_pc, stay in DROP (the last redirect wins).
- Priority: redirect_valid > accept > memory response.
- Reset (any time, including with a request outstanding): state=START, pc=PC_RESET, req_addr=PC_RESET, ibuf=0, exc=0.
  - The outstanding memory transaction is abandoned. The memory must tolerate im_req dropping.

## Timing
- Reset values of outputs: im_req=0, im_addr=PC_RESET, instr_valid=0, instr=0, pc_out=PC_RESET, exc_adel=0.
- First im_req is 1 cycle after reset deasserts (START→REQ).
- im_addr and im_req are stable from the assertion of im_req until the edge where im_ready=1.
- A zero-wait memory (im_ready in the same cycle as im_req) gives instr_valid on the next cycle.
- Steady-state throughput with no stall and zero wait: one instruction per 2 cycles.
- Memory latency of N wait cycles adds N cycles per instruction.
- Redirect in HOLD gives im_req to redirect_pc on the next cycle.
- Redirect during an outstanding request costs a wait for the stale im_ready plus 1 cycle.
- All outputs are combinational from registers, except instr_valid, which also gates on redirect_valid.

## Test plan
- Reset release, zero-wait memory returning mem[i]=0x1000_0000+i, stall=0 → im_addr sequence 0x3000, 0x3004, 0x3008. instr_valid pulses every 2nd cycle with instr 0x1000_0000, 0x1000_0001, 0x1000_0002 and the matching pc_out.
- Memory with 3 wait cycles, plus stall=1 for 4 cycles during HOLD → im_addr is held constant for 4 cycles. instr/pc_out stay 0x1000_0000/0x3000 through the stall, with no new im_req until accept.
- redirect_valid with redirect_pc=0x3100 during the 2nd wait cycle of fetch 0x3004 → stale response discarded (never seen with instr_valid=1). Next im_addr is 0x3100 and pc_out is 0x3100.
- redirect_pc=0x3002, then a separate run with redirect_pc=0x7000 → no im_req. instr_valid=1, exc_adel=1, instr=0, pc_out is the bad address. After accept, fetch halts until redirect_valid with 0x3000 resumes it.
- Run to pc=0x6FFC, then accept → next pc 0x7000 raises exc_adel without a memory request.
- reset asserted mid-request (im_req=1, im_ready=0) → im_req=0 and instr_valid=0 immediately (asynchronously). After release, the first im_addr is 0x3000.

Source files
------------

// File: rtl/fetch_controller_if.sv
// Handshake bundle between the fetch controller, the instruction memory and decode.
// master = fetch controller side, slave = memory/decode environment side.
interface fetch_controller_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready;
  logic [31:0] im_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        exc_adel;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output im_req, im_addr, instr_valid, instr, pc_out, exc_adel,
    input  im_ready, im_rdata, stall, redirect_valid, redirect_pc
  );
  modport slave (
    input  im_req, im_addr, instr_valid, instr, pc_out, exc_adel,
    output im_ready, im_rdata, stall, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, issues word requests over a variable-latency
// req/ready handshake, holds each word for decode and handles redirects and stale responses.
module fetch_controller #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] PC_LOW   = 32'h0000_3000,
  parameter logic [31:0] PC_HIGH  = 32'h0000_6FFC
) (
  input  logic                clk,
  input  logic                reset,
  fetch_controller_if.master  f
);

  typedef enum logic [1:0] {START, REQ, HOLD, DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] ibuf_q, ibuf_d;
  logic        exc_q, exc_d;
  logic        halt_q, halt_d;   // an accepted address exception stops fetch until a redirect
  logic        legal;
  logic        accept;

  assign legal = (pc_q >= PC_LOW) && (pc_q <= PC_HIGH) && (pc_q[1:0] == 2'b00);

  assign f.im_req      = ((state_q == REQ) && legal) || (state_q == DROP);
  assign f.im_addr     = (state_q == DROP) ? req_addr_q : pc_q;
  assign f.instr_valid = (state_q == HOLD) && !halt_q && !f.redirect_valid;
  assign f.instr       = ibuf_q;
  assign f.pc_out      = pc_q;
  assign f.exc_adel    = exc_q;
  assign accept        = f.instr_valid && !f.stall;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    ibuf_d     = ibuf_q;
    exc_d      = exc_q;
    halt_d     = halt_q;
    case (state_q)
      START: state_d = REQ;
      REQ: begin
        if (legal) begin
          req_addr_d = pc_q;
          if (f.redirect_valid) begin
            pc_d    = f.redirect_pc;
            // a response landing with the redirect is already stale; otherwise wait it out
            state_d = f.im_ready ? REQ : DROP;
          end else if (f.im_ready) begin
            ibuf_d  = f.im_rdata;
            exc_d   = 1'b0;
            state_d = HOLD;
          end
        end else if (f.redirect_valid) begin
          pc_d = f.redirect_pc;
        end else begin
          ibuf_d  = '0;
          exc_d   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (f.redirect_valid) begin
          pc_d    = f.redirect_pc;
          halt_d  = 1'b0;
          state_d = REQ;
        end else if (accept) begin
          if (!exc_q) begin
            pc_d    = pc_q + 32'd4;
            state_d = REQ;
          end else begin
            halt_d = 1'b1;
          end
        end
      end
      DROP: begin
        if (f.redirect_valid) pc_d = f.redirect_pc;
        if (f.im_ready) state_d = REQ;
      end
      default: state_d = START;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= START;
      pc_q       <= PC_RESET;
      req_addr_q <= PC_RESET;
      ibuf_q     <= '0;
      exc_q      <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      ibuf_q     <= ibuf_d;
      exc_q      <= exc_d;
      halt_q     <= halt_d;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: variable-latency memory model plus an instruction-stream
// reference (expected next pc / halt) checked at every decode accept.
module tb_fetch_controller;
  localparam logic [31:0] PC_RESET = 32'h0000_3000;

  logic clk = 1'b0;
  logic reset;
  fetch_controller_if f();

  fetch_controller dut (.clk(clk), .reset(reset), .f(f));

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          accepts = 0;
  logic [31:0] m_pc;
  bit          m_halt;
  int          wait_cnt, cur_lat, lat_mode;
  bit          pend;
  logic [31:0] pend_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a >= 32'h3000) && (a <= 32'h6FFC) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + ((a - 32'h3000) >> 2);
  endfunction

  function automatic int pick_lat();
    return (lat_mode < 0) ? int'($urandom_range(3, 0)) : lat_mode;
  endfunction

  // Memory: answers each request after cur_lat wait cycles; checks request stability.
  task automatic mem_step();
    if (pend) begin
      chk("req_held", {31'b0, f.im_req}, 32'd1);
      chk("addr_held", f.im_addr, pend_addr);
    end
    if (f.im_ready) begin
      wait_cnt = 0;
      cur_lat  = pick_lat();
    end
    if (f.im_req) begin
      chk("req_addr_legal", {31'b0, legal(f.im_addr)}, 32'd1);
      if (wait_cnt >= cur_lat) begin
        f.im_ready = 1'b1;
        f.im_rdata = mem_word(f.im_addr);
      end else begin
        f.im_ready = 1'b0;
        f.im_rdata = $urandom;
        wait_cnt++;
      end
    end else begin
      f.im_ready = 1'b0;
      wait_cnt   = 0;
    end
    pend      = f.im_req && !f.im_ready;
    pend_addr = f.im_addr;
  endtask

  task automatic cycle(input bit stl, input bit rv, input logic [31:0] rpc);
    @(negedge clk);
    mem_step();
    f.stall          = stl;
    f.redirect_valid = rv;
    f.redirect_pc    = rpc;
    #1;
    if (rv) begin
      chk("iv_under_redirect", {31'b0, f.instr_valid}, 32'd0);
      m_pc   = rpc;
      m_halt = 1'b0;
    end else if (m_halt) begin
      chk("iv_while_halted", {31'b0, f.instr_valid}, 32'd0);
    end else if (f.instr_valid && !stl) begin
      chk("pc_out", f.pc_out, m_pc);
      chk("exc_adel", {31'b0, f.exc_adel}, {31'b0, !legal(m_pc)});
      chk("instr", f.instr, legal(m_pc) ? mem_word(m_pc) : 32'd0);
      accepts++;
      if (legal(m_pc)) m_pc = m_pc + 32'd4;
      else m_halt = 1'b1;
    end
  endtask

  task automatic do_reset(input int lm);
    reset = 1'b1;
    f.stall = 1'b0; f.redirect_valid = 1'b0; f.redirect_pc = '0;
    f.im_ready = 1'b0; f.im_rdata = '0;
    lat_mode = lm; cur_lat = pick_lat(); wait_cnt = 0; pend = 1'b0;
    m_pc = PC_RESET; m_halt = 1'b0; accepts = 0;
    #1;
    chk("rst_im_req", {31'b0, f.im_req}, 32'd0);
    chk("rst_im_addr", f.im_addr, PC_RESET);
    chk("rst_instr_valid", {31'b0, f.instr_valid}, 32'd0);
    chk("rst_instr", f.instr, 32'd0);
    chk("rst_pc_out", f.pc_out, PC_RESET);
    chk("rst_exc_adel", {31'b0, f.exc_adel}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    #1;
    // zero-wait streaming: one instruction every 2 cycles
    do_reset(0);
    cycle(0, 0, 0);
    chk("first_req", {31'b0, f.im_req}, 32'd1);
    chk("first_addr", f.im_addr, 32'h3000);
    cycle(0, 0, 0);
    chk("zw_iv_on", {31'b0, f.instr_valid}, 32'd1);
    cycle(0, 0, 0);
    chk("zw_iv_off", {31'b0, f.instr_valid}, 32'd0);
    chk("zw_addr2", f.im_addr, 32'h3004);
    repeat (3) cycle(0, 0, 0);
    chk("zw_accepts", accepts, 32'd3);

    // 3 wait cycles, then a 4-cycle stall while holding
    do_reset(3);
    repeat (4) cycle(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0);
      chk("stall_iv", {31'b0, f.instr_valid}, 32'd1);
      chk("stall_req", {31'b0, f.im_req}, 32'd0);
      chk("stall_instr", f.instr, 32'h1000_0000);
      chk("stall_pc", f.pc_out, 32'h3000);
    end
    cycle(0, 0, 0);
    chk("stall_accepts", accepts, 32'd1);

    // redirect during the 2nd wait of fetch 0x3004: stale response must be dropped
    cycle(0, 0, 0);
    cycle(0, 1, 32'h3100);
    repeat (2) cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("redir_req", {31'b0, f.im_req}, 32'd1);
    chk("redir_addr", f.im_addr, 32'h3100);
    repeat (4) cycle(0, 0, 0);
    chk("redir_accepts", accepts, 32'd2);

    // misaligned redirect: exception, halt, then resume at 0x3000
    do_reset(0);
    cycle(0, 0, 0);
    cycle(0, 1, 32'h3002);
    cycle(0, 0, 0);
    chk("unal_no_req", {31'b0, f.im_req}, 32'd0);
    cycle(0, 0, 0);
    chk("unal_accepts", accepts, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0);
      chk("halt_no_req", {31'b0, f.im_req}, 32'd0);
    end
    cycle(0, 1, 32'h3000);
    repeat (2) cycle(0, 0, 0);
    chk("resume_accepts", accepts, 32'd2);

    // out-of-range redirect
    do_reset(0);
    cycle(0, 0, 0);
    cycle(0, 1, 32'h7000);
    cycle(0, 0, 0);
    chk("oor_no_req", {31'b0, f.im_req}, 32'd0);
    cycle(0, 0, 0);
    chk("oor_accepts", accepts, 32'd1);

    // run off the top of memory
    do_reset(0);
    cycle(0, 0, 0);
    cycle(0, 1, 32'h6FF8);
    repeat (6) cycle(0, 0, 0);
    chk("top_accepts", accepts, 32'd3);
    cycle(0, 0, 0);
    chk("top_halt_req", {31'b0, f.im_req}, 32'd0);

    // asynchronous reset with a request outstanding
    do_reset(3);
    cycle(0, 0, 0);
    chk("mid_req_before", {31'b0, f.im_req}, 32'd1);
    do_reset(3);
    cycle(0, 0, 0);
    chk("after_rst_req", {31'b0, f.im_req}, 32'd1);
    chk("after_rst_addr", f.im_addr, 32'h3000);

    // randomized latency, stalls and redirects
    do_reset(-1);
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] t;
      int          sel;
      sel = int'($urandom_range(9, 0));
      if (sel <= 6)      t = 32'h3000 + ({20'b0, 12'($urandom_range(4095, 0))} << 2);
      else if (sel == 7) t = 32'h6FF8;
      else if (sel == 8) t = 32'h7000;
      else               t = 32'h3000 + 32'($urandom_range(3, 1));
      cycle($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 8, t);
    end
    chk("rand_progress", {31'b0, accepts > 150}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
